// File: rtl/osnt_sume_len_fixup.sv
// Store-and-forward length fixup for the OSNT SUME pipeline: buffers whole packets,
// recounts bytes from TKEEP into TUSER[15:0], drops packets too large to buffer.
// Optional: define OSNT_LEN_FIXUP_ORIG_LEN_EN to copy the original length into TUSER[127:112].
module osnt_sume_len_fixup #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int DATA_DEPTH_LOG2    = 9,
    parameter int META_DEPTH_LOG2    = 4
) (
    input  logic                              axi_aclk,
    input  logic                              axi_reset,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,

    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,

    input  logic                              clear_cnt,
    output logic [31:0]                       pkt_cnt,
    output logic [31:0]                       drop_cnt,
    output logic                              oversize_err
);

    localparam int KEEP_W     = C_AXIS_DATA_WIDTH / 8;
    localparam int DATA_DEPTH = 1 << DATA_DEPTH_LOG2;
    localparam int META_DEPTH = 1 << META_DEPTH_LOG2;
    localparam int ENTRY_W    = C_AXIS_DATA_WIDTH + KEEP_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_DROP
    } wr_state_t;

    wr_state_t                     wr_state;

    logic [ENTRY_W-1:0]            data_mem [DATA_DEPTH];
    logic [C_AXIS_TUSER_WIDTH-1:0] meta_mem [META_DEPTH];

    logic [DATA_DEPTH_LOG2:0]      wr_ptr;
    logic [DATA_DEPTH_LOG2:0]      commit_ptr;
    logic [DATA_DEPTH_LOG2:0]      rd_ptr;
    logic [META_DEPTH_LOG2:0]      meta_wr_ptr;
    logic [META_DEPTH_LOG2:0]      meta_rd_ptr;

    logic [15:0]                   byte_cnt;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_hold;

    logic                          data_full;
    logic                          meta_full;
    logic                          meta_empty;
    logic                          data_avail;
    logic                          in_beat;
    logic                          store_beat;
    logic                          commit;
    logic                          oversize;

    logic [15:0]                   beat_bytes;
    logic [15:0]                   cnt_base;
    logic [16:0]                   byte_sum;
    logic [15:0]                   next_cnt;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_base;
    logic [C_AXIS_TUSER_WIDTH-1:0] meta_wdata;

    logic                          out_free;
    logic                          out_done;
    logic                          load;
    logic                          first_next;
    logic [ENTRY_W-1:0]            rd_entry;
    logic [META_DEPTH_LOG2-1:0]    meta_rd_idx;
    logic [C_AXIS_TUSER_WIDTH-1:0] meta_head;

    function automatic logic [15:0] popcount(input logic [KEEP_W-1:0] keep);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            c = c + 16'(keep[i]);
        end
        return c;
    endfunction

    // The read side only ever sees committed beats, so fullness is measured
    // against rd_ptr while availability is measured against commit_ptr.
    assign data_full  = (wr_ptr[DATA_DEPTH_LOG2] != rd_ptr[DATA_DEPTH_LOG2]) &&
                        (wr_ptr[DATA_DEPTH_LOG2-1:0] == rd_ptr[DATA_DEPTH_LOG2-1:0]);
    assign meta_full  = (meta_wr_ptr[META_DEPTH_LOG2] != meta_rd_ptr[META_DEPTH_LOG2]) &&
                        (meta_wr_ptr[META_DEPTH_LOG2-1:0] == meta_rd_ptr[META_DEPTH_LOG2-1:0]);
    assign meta_empty = (meta_wr_ptr == meta_rd_ptr);
    assign data_avail = (rd_ptr != commit_ptr);

    assign s_axis_tready = !axi_reset &&
                           ((wr_state == S_DROP) || (!data_full && !meta_full));
    assign in_beat    = s_axis_tvalid && s_axis_tready;
    assign store_beat = in_beat && (wr_state != S_DROP);
    assign commit     = store_beat && s_axis_tlast;
    // Open packet fills the whole FIFO with nothing committed ahead of it.
    assign oversize   = (wr_state == S_BODY) && data_full && meta_empty;

    assign beat_bytes = popcount(s_axis_tkeep);
    assign cnt_base   = (wr_state == S_IDLE) ? 16'd0 : byte_cnt;
    assign byte_sum   = {1'b0, cnt_base} + {1'b0, beat_bytes};
    assign next_cnt   = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
    assign tuser_base = (wr_state == S_IDLE) ? s_axis_tuser : tuser_hold;

    always_comb begin
        meta_wdata       = tuser_base;
        meta_wdata[15:0] = next_cnt;
`ifdef OSNT_LEN_FIXUP_ORIG_LEN_EN
        meta_wdata[C_AXIS_TUSER_WIDTH-1 -: 16] = tuser_base[15:0];
`else
        meta_wdata[C_AXIS_TUSER_WIDTH-1 -: 16] = tuser_base[C_AXIS_TUSER_WIDTH-1 -: 16];
`endif
    end

    always_ff @(posedge axi_aclk) begin
        if (store_beat) begin
            data_mem[wr_ptr[DATA_DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
        if (commit) begin
            meta_mem[meta_wr_ptr[META_DEPTH_LOG2-1:0]] <= meta_wdata;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            wr_state     <= S_IDLE;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            meta_wr_ptr  <= '0;
            byte_cnt     <= '0;
            tuser_hold   <= '0;
            drop_cnt     <= '0;
            oversize_err <= 1'b0;
        end else begin
            if (store_beat) begin
                wr_ptr   <= wr_ptr + 1'b1;
                byte_cnt <= next_cnt;
                if (wr_state == S_IDLE) begin
                    tuser_hold <= s_axis_tuser;
                end
            end
            if (commit) begin
                commit_ptr  <= wr_ptr + 1'b1;
                meta_wr_ptr <= meta_wr_ptr + 1'b1;
            end

            case (wr_state)
                S_IDLE: begin
                    if (store_beat && !s_axis_tlast) begin
                        wr_state <= S_BODY;
                    end
                end
                S_BODY: begin
                    if (oversize) begin
                        wr_ptr       <= commit_ptr;
                        wr_state     <= S_DROP;
                        oversize_err <= 1'b1;
                        if (drop_cnt != 32'hFFFF_FFFF) begin
                            drop_cnt <= drop_cnt + 1'b1;
                        end
                    end else if (commit) begin
                        wr_state <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (in_beat && s_axis_tlast) begin
                        wr_state <= S_IDLE;
                    end
                end
                default: wr_state <= S_IDLE;
            endcase

            if (clear_cnt) begin
                drop_cnt     <= '0;
                oversize_err <= 1'b0;
            end
        end
    end

    // When the current tlast leaves in the same cycle the next packet's first
    // beat loads, its metadata is the entry just behind the one being popped.
    assign out_free    = !m_axis_tvalid || m_axis_tready;
    assign out_done    = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign load        = out_free && data_avail;
    assign rd_entry    = data_mem[rd_ptr[DATA_DEPTH_LOG2-1:0]];
    assign meta_rd_idx = meta_rd_ptr[META_DEPTH_LOG2-1:0] + META_DEPTH_LOG2'(out_done);
    assign meta_head   = meta_mem[meta_rd_idx];

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            rd_ptr        <= '0;
            meta_rd_ptr   <= '0;
            first_next    <= 1'b1;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            pkt_cnt       <= '0;
        end else begin
            if (load) begin
                rd_ptr        <= rd_ptr + 1'b1;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= rd_entry[ENTRY_W-1];
                m_axis_tkeep  <= rd_entry[C_AXIS_DATA_WIDTH +: KEEP_W];
                m_axis_tdata  <= rd_entry[C_AXIS_DATA_WIDTH-1:0];
                m_axis_tuser  <= first_next ? meta_head : '0;
                first_next    <= rd_entry[ENTRY_W-1];
            end else if (out_free) begin
                m_axis_tvalid <= 1'b0;
            end

            if (out_done) begin
                meta_rd_ptr <= meta_rd_ptr + 1'b1;
                pkt_cnt     <= pkt_cnt + 1'b1;
            end
            if (clear_cnt) begin
                pkt_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_osnt_sume_len_fixup.sv
// Randomized bench for osnt_sume_len_fixup with a packet-level reference model.
// Honours OSNT_LEN_FIXUP_ORIG_LEN_EN when building the expected TUSER.
module tb_osnt_sume_len_fixup;

    localparam int DW   = 256;
    localparam int KW   = DW / 8;
    localparam int UW   = 128;
    localparam int DLOG = 6;
    localparam int MLOG = 4;

    logic            axi_aclk = 1'b0;
    logic            axi_reset;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic [UW-1:0]   s_axis_tuser;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic            clear_cnt;
    logic [31:0]     pkt_cnt;
    logic [31:0]     drop_cnt;
    logic            oversize_err;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    beat_t expq[$];
    int    checks     = 0;
    int    failures   = 0;
    int    in_pkts    = 0;
    int    ready_mode = 1;
    bit    prev_stall = 1'b0;

    always #5 axi_aclk = ~axi_aclk;

    osnt_sume_len_fixup #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .DATA_DEPTH_LOG2   (DLOG),
        .META_DEPTH_LOG2   (MLOG)
    ) dut (
        .axi_aclk     (axi_aclk),
        .axi_reset    (axi_reset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .clear_cnt    (clear_cnt),
        .pkt_cnt      (pkt_cnt),
        .drop_cnt     (drop_cnt),
        .oversize_err (oversize_err)
    );

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [UW-1:0] rand_user();
        logic [UW-1:0] r;
        for (int i = 0; i < UW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Sink ready: 0 = hold low, 1 = hold high, otherwise random per cycle.
    always @(posedge axi_aclk) begin
        #1;
        case (ready_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Any beat presented on m_axis must be the model's next beat, held until taken.
    always @(negedge axi_aclk) begin
        beat_t e;
        if (axi_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) checkOutput("hold_valid", m_axis_tvalid, 1'b1);
            if (m_axis_tvalid) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_beat", expq.size(), 1);
                end else begin
                    e = expq[0];
                    checkOutput("out_data", m_axis_tdata, e.data);
                    checkOutput("out_keep", m_axis_tkeep, e.keep);
                    checkOutput("out_last", m_axis_tlast, e.last);
                    checkOutput("out_user", m_axis_tuser, e.user);
                    if (m_axis_tready) void'(expq.pop_front());
                end
            end
            if (s_axis_tvalid && s_axis_tready && s_axis_tlast) in_pkts++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
        end
    end

    task automatic drive_beat(input logic [DW-1:0] data, input logic [KW-1:0] keep,
                              input logic last, input logic [UW-1:0] user);
        int waited = 0;
        s_axis_tdata  = data;
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        @(negedge axi_aclk);
        while (!s_axis_tready && waited < 5000) begin
            @(negedge axi_aclk);
            waited++;
        end
        if (waited >= 5000) checkOutput("s_tready_timeout", s_axis_tready, 1'b1);
        @(posedge axi_aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Sends one packet and records what should come out, unless it must be dropped.
    task automatic applyStimulus(input int nbeats, input logic [UW-1:0] user,
                                 input logic [KW-1:0] last_keep, input bit rand_keep,
                                 input bit gaps, input bit expect_drop);
        logic [DW-1:0] d[$];
        logic [KW-1:0] k[$];
        logic [KW-1:0] kk;
        int            len = 0;
        for (int i = 0; i < nbeats; i++) begin
            d.push_back(rand_data());
            kk = (i == nbeats - 1) ? last_keep : '1;
            if (rand_keep) kk = $urandom;
            k.push_back(kk);
            len += $countones(kk);
        end
        if (!expect_drop) begin
            for (int i = 0; i < nbeats; i++) begin
                beat_t b;
                b.data = d[i];
                b.keep = k[i];
                b.last = (i == nbeats - 1);
                b.user = '0;
                if (i == 0) begin
                    b.user       = user;
                    b.user[15:0] = (len > 65535) ? 16'hFFFF : 16'(len);
`ifdef OSNT_LEN_FIXUP_ORIG_LEN_EN
                    b.user[UW-1 -: 16] = user[15:0];
`endif
                end
                expq.push_back(b);
            end
        end
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge axi_aclk);
                #1;
            end
            drive_beat(d[i], k[i], i == nbeats - 1, user);
        end
    endtask

    task automatic pulse_clear();
        clear_cnt = 1'b1;
        @(posedge axi_aclk);
        #1;
        clear_cnt = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((expq.size() != 0 || m_axis_tvalid) && n < budget) begin
            @(posedge axi_aclk);
            #1;
            n++;
        end
        checkOutput("drain_left", expq.size(), 0);
        @(posedge axi_aclk);
        #1;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [UW-1:0] u;
        int            base;
        axi_reset     = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        clear_cnt     = 1'b0;
        repeat (3) @(posedge axi_aclk);
        #1;
        checkOutput("rst_s_tready", s_axis_tready, 1'b0);
        checkOutput("rst_m_tvalid", m_axis_tvalid, 1'b0);
        axi_reset = 1'b0;
        @(posedge axi_aclk);
        #1;
        checkOutput("rst_pkt_cnt", pkt_cnt, 0);
        checkOutput("rst_drop_cnt", drop_cnt, 0);
        checkOutput("rst_oversize", oversize_err, 1'b0);
        checkOutput("idle_s_tready", s_axis_tready, 1'b1);

        // Single short beat, with output latency measured from the tlast edge.
        u = rand_user();
        u[15:0] = 16'd1500;
        applyStimulus(1, u, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        checkOutput("lat_cycle1", m_axis_tvalid, 1'b0);
        @(posedge axi_aclk);
        #1;
        checkOutput("lat_cycle2", m_axis_tvalid, 1'b1);
        wait_drain(200);
        checkOutput("single_pkt_cnt", pkt_cnt, 1);

        u = rand_user();
        u[15:0] = 16'd1514;
        applyStimulus(3, u, 32'h0000_000F, 1'b0, 1'b0, 1'b0);
        wait_drain(200);
        checkOutput("three_pkt_cnt", pkt_cnt, 2);

        // Burst into a stalled sink until the metadata FIFO fills.
        ready_mode = 0;
        pulse_clear();
        checkOutput("clear_pkt_cnt", pkt_cnt, 0);
        base = in_pkts;
        fork
            begin
                for (int p = 0; p < 20; p++) applyStimulus(2, rand_user(), '1, 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (100) @(posedge axi_aclk);
                #2;
                checkOutput("meta_full_pkts", in_pkts - base, 16);
                checkOutput("meta_full_tready", s_axis_tready, 1'b0);
                checkOutput("stalled_pkt_cnt", pkt_cnt, 0);
                ready_mode = 1;
            end
        join
        wait_drain(2000);
        checkOutput("burst_pkt_cnt", pkt_cnt, 20);

        // Oversize packet followed by a normal one.
        pulse_clear();
        applyStimulus(70, rand_user(), '1, 1'b0, 1'b0, 1'b1);
        applyStimulus(2, rand_user(), '1, 1'b0, 1'b0, 1'b0);
        wait_drain(500);
        checkOutput("drop_cnt", drop_cnt, 1);
        checkOutput("oversize_err", oversize_err, 1'b1);
        checkOutput("after_drop_pkt_cnt", pkt_cnt, 1);
        pulse_clear();
        checkOutput("clear_drop_cnt", drop_cnt, 0);
        checkOutput("clear_oversize", oversize_err, 1'b0);

        // Random traffic against a random sink.
        pulse_clear();
        ready_mode = 2;
        for (int p = 0; p < 1000; p++) begin
            applyStimulus($urandom_range(1, 12), rand_user(), '1, 1'b1, 1'b1, 1'b0);
        end
        wait_drain(5000);
        ready_mode = 1;
        checkOutput("random_pkt_cnt", pkt_cnt, 1000);
        checkOutput("random_drop_cnt", drop_cnt, 0);

        // Reset with one packet stalled at the output and another half written.
        ready_mode = 0;
        @(posedge axi_aclk);
        #1;
        applyStimulus(2, rand_user(), '1, 1'b0, 1'b0, 1'b0);
        drive_beat(rand_data(), '1, 1'b0, rand_user());
        drive_beat(rand_data(), '1, 1'b0, rand_user());
        repeat (3) @(posedge axi_aclk);
        #1;
        axi_reset = 1'b1;
        @(posedge axi_aclk);
        #1;
        axi_reset = 1'b0;
        expq.delete();
        checkOutput("post_rst_m_tvalid", m_axis_tvalid, 1'b0);
        ready_mode = 1;
        applyStimulus(1, rand_user(), 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        wait_drain(200);
        checkOutput("post_rst_pkt_cnt", pkt_cnt, 1);
        checkOutput("post_rst_drop_cnt", drop_cnt, 0);
        checkOutput("post_rst_oversize", oversize_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/osnt_sume_len_fixup.md
Name: osnt_sume_len_fixup

Overview:
- Store-and-forward stage placed directly downstream of the packet cutter in the OSNT SUME pipeline.
- Buffers each complete packet and recounts its real byte length from TKEEP.
- Rewrites the SUME length field TUSER[15:0] on the first output beat, so truncated packets carry a correct length into the DMA/output queues.
- Drops packets too large to buffer, without corrupting the packets around them.

Parameters:
- C_AXIS_DATA_WIDTH, 256, TDATA width; TKEEP is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, TUSER width; [15:0]=len, [23:16]=src port, [31:24]=dst port.
- DATA_DEPTH_LOG2, 9, log2 beats in data FIFO (512 beats = 16 KB).
- META_DEPTH_LOG2, 4, log2 entries in metadata FIFO (max packets buffered).

Ports:
- axi_aclk  in  1  clock
- axi_reset  in  1  synchronous reset, active-high
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  input data (from packet cutter)
- s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  byte valid mask
- s_axis_tuser  in  C_AXIS_TUSER_WIDTH  metadata, sampled on first beat only
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1
- m_axis_tdata  out  C_AXIS_DATA_WIDTH
- m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  rewritten on first beat, zero on later beats
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- clear_cnt  in  1  one-cycle pulse; zeroes both counters
- pkt_cnt  out  32  packets emitted on m_axis (counted at m_axis tlast handshake)
- drop_cnt  out  32  oversize packets dropped
- oversize_err  out  1  sticky flag; cleared only by clear_cnt or reset

Behaviour:
- Reset: all outputs 0. Both FIFOs empty. Write-side FSM in IDLE. Read-side pipeline empty.
- Write side: data FIFO keeps two write pointers, wr_ptr (speculative) and commit_ptr (visible to the read side).
- s_axis_tready = !data_full && !meta_full, except in DROP, where it is 1.
- Write FSM, IDLE:
  - On the first accepted beat: latch s_axis_tuser and start the byte count with popcount(tkeep).
  - If that beat also has tlast, commit immediately; otherwise go to BODY.
- Write FSM, BODY:
  - Each accepted beat adds popcount(tkeep) to the count.
  - Count is 16-bit and saturates at 0xFFFF; it never wraps.
- Commit (at tlast):
  - Push {tuser with [15:0] replaced by the count} into the meta FIFO.
  - Same cycle: commit_ptr <= wr_ptr+1. Return to IDLE.
- Oversize: if data FIFO is full while meta FIFO is empty and a packet is open, that packet cannot fit.
  - wr_ptr <= commit_ptr (rollback); go to DROP.
  - oversize_err <= 1; drop_cnt +1 (saturating).
- Write FSM, DROP: accepts and discards beats until the tlast beat, then returns to IDLE. No meta push.
- Read side:
  - Meta entry is visible one cycle after the commit.
  - m_axis is a registered output stage.
  - Latency: tlast accepted at cycle N -> first m_axis_tvalid no earlier than N+2 (output idle).
- First output beat carries the meta tuser. Later beats carry tuser=0. The meta entry pops on the tlast handshake.
- Output rules:
  - tdata/tkeep/tlast are passed unchanged from the data FIFO.
  - m_axis_tvalid stays high and outputs stay stable while tready=0.
  - Back-to-back packets are allowed with no bubble.
- Simultaneous events:
  - Push and pop in the same cycle are both legal on both FIFOs.
  - clear_cnt together with an increment: clear wins.
- Pointers: DATA_DEPTH_LOG2+1 bits, so full/empty are distinguished by the MSB; wrap-around is seamless.
- Reset mid-packet: partial input and the output packet in flight are discarded; the FSM returns to IDLE.

Optional Feature:
- Macro: OSNT_LEN_FIXUP_ORIG_LEN_EN.
- Defined: the original input TUSER[15:0] is also copied into output TUSER[127:112] on the first beat, so software sees both the pre-cut and post-cut length.
- Undefined: TUSER[127:112] passes through unchanged from the input first beat.

Test Plan:
- 1 beat, tkeep=0x0000_FFFF, tuser[15:0]=1500 -> out tuser[15:0]=16, tlast on beat 1, pkt_cnt=1, first tvalid 2 cycles after input tlast.
- 3 beats, tkeep all-ones, all-ones, 0x0000_000F, tuser len=1514 -> out len=68. With OSNT_LEN_FIXUP_ORIG_LEN_EN defined, tuser[127:112]=1514.
- 20 back-to-back 2-beat packets with m_axis_tready held 0 for 100 cycles, then 1 -> s_axis_tready drops once meta FIFO full (16 packets); all 20 later emitted in order, data intact, pkt_cnt=20.
- With DATA_DEPTH_LOG2=4, send 20-beat packet followed by 2-beat packet -> first packet dropped, drop_cnt=1, oversize_err=1; second emitted correctly with len=64.
- Random m_axis_tready (50%) over 1000 random-length packets -> scoreboard matches data and computed lengths; outputs never change while tvalid=1 and tready=0.
- Assert axi_reset mid-packet for 1 cycle, then send 1-beat packet -> only the new packet emitted, counters 0 except pkt_cnt=1.
